// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------------------------
// fetch_pc_unit
//
// Registered program counter for the Fetch stage with a return-address stack (RAS).
// Each clock edge the PC advances sequentially, takes a resolved branch/J/JR target, holds
// on stall, or loads a flush target. Link jumps push their return address onto the RAS and
// returns pop it. The stack top is exported for return prediction only and never steers
// the PC.
//
// Ports:
//   i_clk          clock; all state updates on the rising edge
//   i_rst          synchronous active-high reset
//   i_stall        hold PC and RAS; resolution inputs ignored
//   i_flush        load i_flush_pc; beats stall and branches
//   i_flush_pc     flush target
//   i_branch       00 none, 01 conditional branch, 10 J, 11 JR
//   i_branch_dec   conditional branch outcome (1 = taken)
//   i_imm          signed PC-relative offset
//   i_read1data    register value used as JR target
//   i_branch_pc    PC of the resolving branch
//   i_link         J/JR pushes its return address
//   i_ret          JR pops the RAS
//   o_pc           current fetch PC
//   o_redirect     pulse: o_pc was loaded from a non-sequential source
//   o_ras_top      top RAS entry, 0 when empty
//   o_ras_empty    RAS holds no entries
//   o_ras_full     RAS holds RAS_DEPTH entries
// ---------------------------------------------------------------------------------------------
module fetch_pc_unit #(
   parameter int unsigned PC_BITS   = 16,
   parameter int unsigned RESET_PC  = 0,
   parameter int unsigned PC_INC    = 1,
   parameter int unsigned RAS_DEPTH = 4   // power of two, >= 2
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_stall,
   input  logic               i_flush,
   input  logic [PC_BITS-1:0] i_flush_pc,
   input  logic [1:0]         i_branch,
   input  logic               i_branch_dec,
   input  logic [31:0]        i_imm,
   input  logic [31:0]        i_read1data,
   input  logic [PC_BITS-1:0] i_branch_pc,
   input  logic               i_link,
   input  logic               i_ret,
   output logic [PC_BITS-1:0] o_pc,
   output logic               o_redirect,
   output logic [PC_BITS-1:0] o_ras_top,
   output logic               o_ras_empty,
   output logic               o_ras_full
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [PC_BITS-1:0] RESET_PC_V = PC_BITS'(RESET_PC);
   localparam logic [PC_BITS-1:0] PC_INC_V   = PC_BITS'(PC_INC);
   localparam logic [CNT_W-1:0]   DEPTH_V    = CNT_W'(RAS_DEPTH);
   localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);
   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_COND = 2'b01;
   localparam logic [1:0] BR_J    = 2'b10;
   localparam logic [1:0] BR_JR   = 2'b11;

   // ------------------------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------------------------
   logic [PC_BITS-1:0] r_pc;
   logic               r_redirect;
   logic [PC_BITS-1:0] r_ras [RAS_DEPTH];
   // r_ptr is the next write slot; the top entry lives at r_ptr-1. Because the pointer wraps,
   // a push into a full stack lands on the oldest entry.
   logic [PTR_W-1:0]   r_ptr;
   logic [CNT_W-1:0]   r_cnt;

   // ------------------------------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------------------------------
   logic               w_taken;
   logic [PC_BITS-1:0] w_target;
   logic [PC_BITS-1:0] w_pc_next;
   logic               w_redirect_next;
   logic               w_ras_en;
   logic               w_push;
   logic               w_pop;
   logic [PC_BITS-1:0] w_ret_addr;
   logic [PTR_W-1:0]   w_top_idx;
   logic [PTR_W-1:0]   w_ptr_next;
   logic [CNT_W-1:0]   w_cnt_next;
   logic               w_we;
   logic [PTR_W-1:0]   w_wr_idx;
   logic               w_empty;

   // ------------------------------------------------------------------------------------------
   // Branch decode and target selection
   // ------------------------------------------------------------------------------------------
   always_comb begin
      w_taken = 1'b0;
      unique case (i_branch)
         BR_NONE: w_taken = 1'b0;
         BR_COND: w_taken = i_branch_dec;
         BR_J:    w_taken = 1'b1;
         BR_JR:   w_taken = 1'b1;
         default: w_taken = 1'b0;
      endcase
   end

   // JR takes the register value; the upper bits beyond PC_BITS are dropped.
   assign w_target = (i_branch == BR_JR) ? i_read1data[PC_BITS-1:0]
                                         : i_branch_pc + i_imm[PC_BITS-1:0];

   // ------------------------------------------------------------------------------------------
   // Next PC: flush > stall > taken > sequential (reset handled in the register)
   // ------------------------------------------------------------------------------------------
   always_comb begin
      w_pc_next       = r_pc + PC_INC_V;
      w_redirect_next = 1'b0;
      if (i_flush) begin
         w_pc_next       = i_flush_pc;
         w_redirect_next = 1'b1;
      end else if (i_stall) begin
         w_pc_next       = r_pc;
         w_redirect_next = 1'b0;
      end else if (w_taken) begin
         w_pc_next       = w_target;
         w_redirect_next = 1'b1;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Return-address stack control
   // ------------------------------------------------------------------------------------------
   assign w_ras_en   = !i_flush && !i_stall;
   assign w_push     = w_ras_en && i_link && i_branch[1];
   assign w_pop      = w_ras_en && i_ret && (i_branch == BR_JR);
   assign w_ret_addr = i_branch_pc + PC_INC_V;
   assign w_top_idx  = r_ptr - PTR_ONE;
   assign w_empty    = (r_cnt == '0);

   always_comb begin
      w_ptr_next = r_ptr;
      w_cnt_next = r_cnt;
      w_we       = 1'b0;
      w_wr_idx   = r_ptr;
      if (w_push && w_pop) begin
         // Pop-then-push collapses to replacing the top; on an empty stack it is a plain push.
         w_we = 1'b1;
         if (w_empty) begin
            w_wr_idx   = r_ptr;
            w_ptr_next = r_ptr + PTR_ONE;
            w_cnt_next = CNT_ONE;
         end else begin
            w_wr_idx = w_top_idx;
         end
      end else if (w_push) begin
         w_we       = 1'b1;
         w_wr_idx   = r_ptr;
         w_ptr_next = r_ptr + PTR_ONE;
         if (r_cnt != DEPTH_V) begin
            w_cnt_next = r_cnt + CNT_ONE;
         end
      end else if (w_pop && !w_empty) begin
         w_ptr_next = w_top_idx;
         w_cnt_next = r_cnt - CNT_ONE;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc       <= RESET_PC_V;
         r_redirect <= 1'b0;
         r_ptr      <= '0;
         r_cnt      <= '0;
         for (int i = 0; i < int'(RAS_DEPTH); i++) begin
            r_ras[i] <= '0;
         end
      end else begin
         r_pc       <= w_pc_next;
         r_redirect <= w_redirect_next;
         r_ptr      <= w_ptr_next;
         r_cnt      <= w_cnt_next;
         if (w_we) begin
            r_ras[w_wr_idx] <= w_ret_addr;
         end
      end
   end

   // ------------------------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------------------------
   assign o_pc        = r_pc;
   assign o_redirect  = r_redirect;
   assign o_ras_empty = w_empty;
   assign o_ras_full  = (r_cnt == DEPTH_V);
   assign o_ras_top   = w_empty ? '0 : r_ras[w_top_idx];

endmodule

// File: tb/tb_fetch_pc_unit.sv
// ---------------------------------------------------------------------------------------------
// tb_fetch_pc_unit
//
// Directed bench for fetch_pc_unit (PC_BITS=16, RESET_PC=0, PC_INC=1, RAS_DEPTH=4).
// The driver applies one vector per cycle at the falling edge and queues the outputs
// expected after the next rising edge; an independent monitor pops and compares them.
// ---------------------------------------------------------------------------------------------
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] flush_pc = '0;
   logic [1:0]  branch = 2'b00;
   logic        branch_dec = 1'b0;
   logic [31:0] imm = '0;
   logic [31:0] read1data = '0;
   logic [15:0] branch_pc = '0;
   logic        link = 1'b0;
   logic        ret = 1'b0;
   logic [15:0] pc;
   logic        redirect;
   logic [15:0] ras_top;
   logic        ras_empty;
   logic        ras_full;

   fetch_pc_unit #(
      .PC_BITS   (16),
      .RESET_PC  (0),
      .PC_INC    (1),
      .RAS_DEPTH (4)
   ) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_stall      (stall),
      .i_flush      (flush),
      .i_flush_pc   (flush_pc),
      .i_branch     (branch),
      .i_branch_dec (branch_dec),
      .i_imm        (imm),
      .i_read1data  (read1data),
      .i_branch_pc  (branch_pc),
      .i_link       (link),
      .i_ret        (ret),
      .o_pc         (pc),
      .o_redirect   (redirect),
      .o_ras_top    (ras_top),
      .o_ras_empty  (ras_empty),
      .o_ras_full   (ras_full)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] pc;
      logic        redir;
      logic [15:0] top;
      logic        empty;
      logic        full;
      int          id;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   vec_id   = 0;

   task automatic chk(input string name, input int id, input logic [31:0] act,
                      input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL vec%0d %s: actual=%0h required=%0h", id, name, act, req);
   endtask

   // Monitor: outputs are sampled 1 time unit after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc",        e.id, 32'(pc),        32'(e.pc));
            chk("redirect",  e.id, 32'(redirect),  32'(e.redir));
            chk("ras_top",   e.id, 32'(ras_top),   32'(e.top));
            chk("ras_empty", e.id, 32'(ras_empty), 32'(e.empty));
            chk("ras_full",  e.id, 32'(ras_full),  32'(e.full));
         end
      end
   end

   task automatic start();
      @(negedge clk);
      rst        = 1'b0;
      stall      = 1'b0;
      flush      = 1'b0;
      flush_pc   = '0;
      branch     = 2'b00;
      branch_dec = 1'b0;
      imm        = '0;
      read1data  = '0;
      branch_pc  = '0;
      link       = 1'b0;
      ret        = 1'b0;
   endtask

   task automatic exp_push(input logic [15:0] e_pc, input logic e_redir, input logic [15:0] e_top,
                           input logic e_empty, input logic e_full);
      exp_t e;
      e.pc    = e_pc;
      e.redir = e_redir;
      e.top   = e_top;
      e.empty = e_empty;
      e.full  = e_full;
      e.id    = vec_id;
      vec_id++;
      q.push_back(e);
   endtask

   // J / conditional branch helper
   task automatic jump(input logic [1:0] br, input logic dec, input logic [15:0] bpc,
                       input logic [31:0] off, input logic lnk);
      start();
      branch = br; branch_dec = dec; branch_pc = bpc; imm = off; link = lnk;
   endtask

   // JR helper
   task automatic jr(input logic [31:0] r1, input logic [15:0] bpc, input logic lnk,
                     input logic rt);
      start();
      branch = 2'b11; read1data = r1; branch_pc = bpc; link = lnk; ret = rt;
   endtask

   initial begin
      // Reset, then sequential fetch
      start(); rst = 1'b1;                       exp_push(16'h0000, 0, 16'h0000, 1, 0);
      start();                                   exp_push(16'h0001, 0, 16'h0000, 1, 0);
      start();                                   exp_push(16'h0002, 0, 16'h0000, 1, 0);
      start();                                   exp_push(16'h0003, 0, 16'h0000, 1, 0);
      // Conditional branch taken (negative offset) and not taken
      jump(2'b01, 1, 16'h0010, 32'hFFFF_FFFC, 0); exp_push(16'h000C, 1, 16'h0000, 1, 0);
      jump(2'b01, 0, 16'h0010, 32'hFFFF_FFFC, 0); exp_push(16'h000D, 0, 16'h0000, 1, 0);
      // JR drops upper bits; stall beats JR; flush beats stall
      jr(32'hABCD_1234, 16'h0000, 0, 0);          exp_push(16'h1234, 1, 16'h0000, 1, 0);
      jr(32'hABCD_1234, 16'h0000, 0, 0); stall = 1'b1;
                                                 exp_push(16'h1234, 0, 16'h0000, 1, 0);
      jr(32'hABCD_1234, 16'h0000, 0, 0); stall = 1'b1; flush = 1'b1; flush_pc = 16'h0200;
                                                 exp_push(16'h0200, 1, 16'h0000, 1, 0);
      start();                                   exp_push(16'h0201, 0, 16'h0000, 1, 0);
      // Five link jumps into a 4-deep stack: oldest entry overwritten
      jump(2'b10, 0, 16'h0010, 32'h0, 1);        exp_push(16'h0010, 1, 16'h0011, 0, 0);
      jump(2'b10, 0, 16'h0020, 32'h0, 1);        exp_push(16'h0020, 1, 16'h0021, 0, 0);
      jump(2'b10, 0, 16'h0030, 32'h0, 1);        exp_push(16'h0030, 1, 16'h0031, 0, 0);
      jump(2'b10, 0, 16'h0040, 32'h0, 1);        exp_push(16'h0040, 1, 16'h0041, 0, 1);
      jump(2'b10, 0, 16'h0050, 32'h0, 1);        exp_push(16'h0050, 1, 16'h0051, 0, 1);
      // Four returns drain it; fifth is ignored. PC follows read1data, not the RAS.
      jr(32'h0000_0300, 16'h0000, 0, 1);          exp_push(16'h0300, 1, 16'h0041, 0, 0);
      jr(32'h0000_0310, 16'h0000, 0, 1);          exp_push(16'h0310, 1, 16'h0031, 0, 0);
      jr(32'h0000_0320, 16'h0000, 0, 1);          exp_push(16'h0320, 1, 16'h0021, 0, 0);
      jr(32'h0000_0330, 16'h0000, 0, 1);          exp_push(16'h0330, 1, 16'h0000, 1, 0);
      jr(32'h0000_0340, 16'h0000, 0, 1);          exp_push(16'h0340, 1, 16'h0000, 1, 0);
      // Stall and flush both suppress a push; link on a conditional branch is ignored
      jump(2'b10, 0, 16'h0060, 32'h0, 1); stall = 1'b1;
                                                 exp_push(16'h0340, 0, 16'h0000, 1, 0);
      jump(2'b10, 0, 16'h0060, 32'h0, 1); flush = 1'b1; flush_pc = 16'h0400;
                                                 exp_push(16'h0400, 1, 16'h0000, 1, 0);
      jump(2'b01, 1, 16'h0400, 32'h4, 1);         exp_push(16'h0404, 1, 16'h0000, 1, 0);
      // PC wrap on sequential step and on target arithmetic
      start(); flush = 1'b1; flush_pc = 16'hFFFF; exp_push(16'hFFFF, 1, 16'h0000, 1, 0);
      start();                                   exp_push(16'h0000, 0, 16'h0000, 1, 0);
      jump(2'b10, 0, 16'hFFF0, 32'h20, 0);        exp_push(16'h0010, 1, 16'h0000, 1, 0);
      // Build count=2 with top 0x51, then JALR replaces top
      jump(2'b10, 0, 16'h0040, 32'h0, 1);        exp_push(16'h0040, 1, 16'h0041, 0, 0);
      jump(2'b10, 0, 16'h0050, 32'h0, 1);        exp_push(16'h0050, 1, 16'h0051, 0, 0);
      jr(32'h0000_0500, 16'h0100, 1, 1);          exp_push(16'h0500, 1, 16'h0101, 0, 0);
      jr(32'h0000_0600, 16'h0000, 0, 1);          exp_push(16'h0600, 1, 16'h0041, 0, 0);
      jr(32'h0000_0610, 16'h0000, 0, 1);          exp_push(16'h0610, 1, 16'h0000, 1, 0);
      // Push+pop on an empty stack acts as a push; ret with J is ignored
      jr(32'h0000_0800, 16'h0700, 1, 1);          exp_push(16'h0800, 1, 16'h0701, 0, 0);
      jump(2'b10, 0, 16'h0800, 32'h10, 0); ret = 1'b1;
                                                 exp_push(16'h0810, 1, 16'h0701, 0, 0);
      // Return address wraps to 0 yet the stack is non-empty
      jump(2'b10, 0, 16'hFFFF, 32'h1, 1);         exp_push(16'h0000, 1, 16'h0000, 0, 0);
      // Reset during a push wins
      jump(2'b10, 0, 16'h0900, 32'h0, 1); rst = 1'b1;
                                                 exp_push(16'h0000, 0, 16'h0000, 1, 0);
      start();                                   exp_push(16'h0001, 0, 16'h0000, 1, 0);

      // Let the monitor drain the queue, bounded
      for (int i = 0; i < 10; i++) begin
         if (q.size() == 0) break;
         @(negedge clk);
      end
      if (q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: actual=%0d pending required=0 pending", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
